// File: rtl/wrapper_ahb_packet_writer.sv
// ============================================================================
//  Module      : wrapper_ahb_packet_writer
//  Description : AHB-Lite initiator that takes one wide packet on a
//                valid/ready port and writes it as an incrementing burst of
//                32-bit words into an accelerator wrapper's input window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrapper_ahb_packet_writer #(
  parameter int ADDRWIDTH   = 12,
  parameter int PACKETWIDTH = 512,
  parameter int BASEADDR    = 'h000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PACKETWIDTH-1:0] packet_data,
  input  logic                   packet_data_last,
  input  logic                   packet_data_valid,
  output logic                   packet_data_ready,
  input  logic                   data_req,
  output logic                   hsel,
  output logic [ADDRWIDTH-1:0]   haddr,
  output logic [1:0]             htrans,
  output logic [2:0]             hsize,
  output logic                   hwrite,
  output logic [31:0]            hwdata,
  input  logic                   hready,
  input  logic                   hresp,
  output logic                   busy,
  output logic                   error
);

  localparam int c_NWORDS = PACKETWIDTH / 32;
  localparam int c_CNTW   = $clog2(c_NWORDS);

  localparam logic [ADDRWIDTH-1:0] c_BASE      = ADDRWIDTH'(BASEADDR);
  // Final packet of a block lands at the top of the window.
  localparam logic [ADDRWIDTH-1:0] c_TOP_OFF   = ADDRWIDTH'((1 << (ADDRWIDTH - 1)) - PACKETWIDTH / 8);
  localparam logic [ADDRWIDTH-1:0] c_WORD_STEP = ADDRWIDTH'(4);
  localparam logic [c_CNTW-1:0]    c_LAST_WORD = c_CNTW'(c_NWORDS - 1);
  localparam logic [c_CNTW-1:0]    c_CNT_ONE   = c_CNTW'(1);

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_XFER     = 2'd1,
    S_LASTDATA = 2'd2,
    S_ERR1     = 2'd3
  } state_t;

  state_t                 r_state;
  logic [PACKETWIDTH-1:0] r_shift;
  logic [c_CNTW-1:0]      r_cnt;
  logic                   r_dphase;
  logic                   r_ready;
  logic                   r_hsel;
  logic [ADDRWIDTH-1:0]   r_haddr;
  logic [1:0]             r_htrans;
  logic                   r_hwrite;
  logic [31:0]            r_hwdata;
  logic                   r_busy;
  logic                   r_error;

  logic w_handshake;
  logic w_err_first;

  assign w_handshake = r_ready & packet_data_valid;

  // First ERROR cycle of a data phase: the pending address phase is cancelled
  // in that same cycle, so htrans is forced to IDLE combinationally.
  assign w_err_first = r_dphase & hresp & ~hready &
                       ((r_state == S_XFER) | (r_state == S_LASTDATA));

  assign packet_data_ready = r_ready;
  assign hsel              = r_hsel;
  assign haddr             = r_haddr;
  assign htrans            = w_err_first ? c_HTRANS_IDLE : r_htrans;
  assign hsize             = 3'b010;
  assign hwrite            = r_hwrite;
  assign hwdata            = r_hwdata;
  assign busy              = r_busy;
  assign error             = r_error;

  // Packet FSM: handshake, address/data pipeline, completion and error abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_dphase <= 1'b0;
      r_ready  <= 1'b0;
      r_hsel   <= 1'b0;
      r_haddr  <= '0;
      r_htrans <= c_HTRANS_IDLE;
      r_hwrite <= 1'b0;
      r_hwdata <= '0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= data_req;
          if (w_handshake) begin
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_shift  <= packet_data;
            r_cnt    <= '0;
            r_haddr  <= c_BASE + (packet_data_last ? c_TOP_OFF : '0);
            r_htrans <= c_HTRANS_NONSEQ;
            r_hsel   <= 1'b1;
            r_hwrite <= 1'b1;
            r_state  <= S_XFER;
          end
        end

        S_XFER: begin
          if (w_err_first) begin
            r_htrans <= c_HTRANS_IDLE;
            r_hsel   <= 1'b0;
            r_hwrite <= 1'b0;
            r_state  <= S_ERR1;
          end else if (hready) begin
            // Address phase accepted: its word becomes the next data phase.
            r_hwdata <= r_shift[31:0];
            r_shift  <= r_shift >> 32;
            r_dphase <= 1'b1;
            if (r_cnt == c_LAST_WORD) begin
              r_htrans <= c_HTRANS_IDLE;
              r_hsel   <= 1'b0;
              r_hwrite <= 1'b0;
              r_state  <= S_LASTDATA;
            end else begin
              r_cnt    <= r_cnt + c_CNT_ONE;
              r_haddr  <= r_haddr + c_WORD_STEP;
              r_htrans <= c_HTRANS_SEQ;
            end
          end
        end

        S_LASTDATA: begin
          if (w_err_first) begin
            r_state <= S_ERR1;
          end else if (hready) begin
            r_dphase <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= data_req;
            r_state  <= S_IDLE;
          end
        end

        S_ERR1: begin
          // Second ERROR cycle completes the response; remaining words dropped.
          if (hready) begin
            r_error  <= 1'b1;
            r_dphase <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= data_req;
            r_state  <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wrapper_ahb_packet_writer.sv
// ============================================================================
//  Module      : tb_wrapper_ahb_packet_writer
//  Description : Self-checking bench for wrapper_ahb_packet_writer. A bus
//                monitor collects completed writes; a reference model derives
//                expected addresses, data and packet period.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wrapper_ahb_packet_writer;

  localparam int AW   = 12;
  localparam int PW   = 512;
  localparam int BASE = 'h000;
  localparam int N    = PW / 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] packet_data = '0;
  logic          packet_data_last = 1'b0;
  logic          packet_data_valid = 1'b0;
  logic          data_req = 1'b0;
  logic          hready = 1'b1;
  logic          hresp = 1'b0;
  logic          packet_data_ready;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hwrite;
  logic [31:0]   hwdata;
  logic          busy;
  logic          error;

  wrapper_ahb_packet_writer #(
    .ADDRWIDTH(AW), .PACKETWIDTH(PW), .BASEADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .packet_data(packet_data), .packet_data_last(packet_data_last),
    .packet_data_valid(packet_data_valid), .packet_data_ready(packet_data_ready),
    .data_req(data_req),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hresp(hresp),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: where word k of a packet must be written.
  function automatic logic [AW-1:0] exp_addr(input bit last, input int k);
    int off;
    off = last ? ((2 ** (AW - 1)) - PW / 8) : 0;
    return AW'(BASE + off + 4 * k);
  endfunction

  // Bus monitor: records every completed OKAY write and checks stall holding.
  logic [AW-1:0] got_a[$];
  logic [31:0]   got_d[$];
  logic [1:0]    got_t[$];
  int            err_cnt = 0;
  logic          pend = 1'b0;
  logic [AW-1:0] pend_a;
  logic          p_stall = 1'b0;
  logic [AW-1:0] p_addr;
  logic [1:0]    p_trans;
  logic [31:0]   p_wdata;

  always @(negedge clk) begin
    if (rst) begin
      pend    = 1'b0;
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk_eq("hold_haddr", haddr, p_addr);
        chk_eq("hold_htrans", htrans, p_trans);
        chk_eq("hold_hwdata", hwdata, p_wdata);
      end
      if (pend && hready) begin
        if (!hresp) begin
          got_a.push_back(pend_a);
          got_d.push_back(hwdata);
        end
        pend = 1'b0;
      end
      if (htrans[1]) begin
        chk_eq("hsel_hwrite", {hsel, hwrite}, 2'b11);
        if (hready) begin
          pend   = 1'b1;
          pend_a = haddr;
          got_t.push_back(htrans);
        end
      end
      p_stall = busy && !hready && !hresp;
      p_addr  = haddr;
      p_trans = htrans;
      p_wdata = hwdata;
      if (error) err_cnt++;
    end
  end

  // Offer the current packet and wait for the handshake; returns at the
  // start of the first cycle after the handshake with valid dropped.
  task automatic wait_hs(output int hs_wait);
    hs_wait = 0;
    packet_data_valid = 1'b1;
    @(negedge clk);
    while (!packet_data_ready) begin
      hs_wait++;
      if (hs_wait > 50) begin
        chk_eq("handshake_timeout", 0, 1);
        packet_data_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    packet_data_valid = 1'b0;
  endtask

  // Send one packet with hready forced low in cycles [stall_at, stall_at+stall_len)
  // after the handshake plus random stalls; checks period and all writes.
  task automatic run_packet(input logic [PW-1:0] pkt, input bit last, input int stall_pct,
                            input int stall_at, input int stall_len,
                            output int period, output int hs_wait);
    int zeros;
    got_a.delete(); got_d.delete(); got_t.delete();
    packet_data = pkt;
    packet_data_last = last;
    wait_hs(hs_wait);
    zeros  = 0;
    period = -1;
    for (int e = 1; e < 400; e++) begin
      hready = ($urandom_range(99) >= stall_pct) &&
               !(e >= stall_at && e < stall_at + stall_len);
      @(negedge clk);
      if (packet_data_ready) begin
        period = e;
        break;
      end
      if (!hready) zeros++;
      @(posedge clk); #1;
    end
    hready = 1'b1;
    @(posedge clk); #1;
    chk_eq("period", period, N + 2 + zeros);
    chk_eq("n_writes", got_a.size(), N);
    for (int k = 0; k < N && k < got_a.size(); k++) begin
      chk_eq("wr_addr", got_a[k], exp_addr(last, k));
      chk_eq("wr_data", got_d[k], pkt[32*k +: 32]);
      chk_eq("wr_trans", got_t[k], (k == 0) ? 2'b10 : 2'b11);
    end
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    logic [PW-1:0] p;
    for (int k = 0; k < N; k++) p[32*k +: 32] = $urandom;
    return p;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PW-1:0] pkt;
    int per;
    int hsw;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_eq("rst_ready", packet_data_ready, 0);
    chk_eq("rst_hsel", hsel, 0);
    chk_eq("rst_haddr", haddr, 0);
    chk_eq("rst_htrans", htrans, 0);
    chk_eq("rst_hwrite", hwrite, 0);
    chk_eq("rst_hwdata", hwdata, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_error", error, 0);
    chk_eq("rst_hsize", hsize, 3'b010);
    @(posedge clk); #1;
    rst = 1'b0;
    data_req = 1'b1;
    @(posedge clk); #1;

    // Counting-pattern packet, normal then last
    for (int k = 0; k < N; k++) pkt[32*k +: 32] = k;
    run_packet(pkt, 1'b0, 0, 0, 0, per, hsw);
    chk_eq("period_basic", per, N + 2);
    run_packet(pkt, 1'b1, 0, 0, 0, per, hsw);
    chk_eq("period_last", per, N + 2);

    // Three wait states in the word-5 data phase
    run_packet(pkt, 1'b0, 0, 7, 3, per, hsw);
    chk_eq("period_stall", per, N + 5);

    // data_req low blocks the start
    data_req = 1'b0;
    @(posedge clk); #1;
    packet_data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("noreq_ready", packet_data_ready, 0);
      chk_eq("noreq_htrans", htrans, 0);
      @(posedge clk); #1;
    end
    data_req = 1'b1;
    @(negedge clk);
    chk_eq("req_lag_ready", packet_data_ready, 0);
    @(posedge clk); #1;
    run_packet(rand_pkt(), 1'b0, 0, 0, 0, per, hsw);
    chk_eq("req_start_wait", hsw, 0);

    // ERROR response on the word-3 data phase
    pkt = rand_pkt();
    got_a.delete(); got_d.delete(); got_t.delete();
    err_cnt = 0;
    packet_data = pkt;
    packet_data_last = 1'b0;
    wait_hs(hsw);
    repeat (4) @(posedge clk);
    #1;
    hready = 1'b0;
    hresp  = 1'b1;
    @(negedge clk);
    chk_eq("err_htrans_idle", htrans, 0);
    chk_eq("err_busy", busy, 1);
    @(posedge clk); #1;
    hready = 1'b1;
    @(negedge clk);
    chk_eq("err_not_yet", error, 0);
    @(posedge clk); #1;
    hresp = 1'b0;
    @(negedge clk);
    chk_eq("err_pulse", error, 1);
    chk_eq("err_busy_fall", busy, 0);
    repeat (20) @(posedge clk);
    #1;
    chk_eq("err_count", err_cnt, 1);
    chk_eq("err_n_writes", got_a.size(), 3);
    for (int k = 0; k < 3 && k < got_a.size(); k++) begin
      chk_eq("err_wr_addr", got_a[k], exp_addr(1'b0, k));
      chk_eq("err_wr_data", got_d[k], pkt[32*k +: 32]);
    end

    // Reset while word 7 is on the bus
    packet_data = rand_pkt();
    wait_hs(hsw);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_eq("mid_rst_ready", packet_data_ready, 0);
    chk_eq("mid_rst_hsel", hsel, 0);
    chk_eq("mid_rst_haddr", haddr, 0);
    chk_eq("mid_rst_htrans", htrans, 0);
    chk_eq("mid_rst_hwrite", hwrite, 0);
    chk_eq("mid_rst_hwdata", hwdata, 0);
    chk_eq("mid_rst_busy", busy, 0);
    chk_eq("mid_rst_error", error, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_packet(rand_pkt(), 1'b0, 0, 0, 0, per, hsw);

    // Random packets with random wait states
    for (int i = 0; i < 12; i++)
      run_packet(rand_pkt(), 1'($urandom_range(1)), 30, 0, 0, per, hsw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
